keypad_loader: RTL and testbench

Upstream input stage of the microwave controller. Synchronises and debounces the 10-key one-hot keypad and encodes each accepted press to BCD. Each accepted digit is shifted into a 3-digit entry register (min : sec_tens sec_ones). The entry register and the accept strobe feed the countdown/display core, which loads them on start.

---
 rtl/keypad_loader.sv | 104 ++++++++++
 tb/tb_keypad_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_loader.sv
// keypad_loader: synchronise, debounce and BCD-encode a one-hot 10-key keypad into a 3-digit entry register
// Ports:
//   clock       rising-edge system clock
//   clearn      asynchronous active-low reset
//   keypad      raw one-hot keys, bit i = digit i, asynchronous to clock
//   load_en     1 = accepted digits shift into the entry register, 0 = frozen
//   key_valid   one-cycle pulse per accepted press
//   key_code    BCD of the last accepted key
//   min/sec_tens/sec_ones  entry register (min : sec_tens sec_ones)
//   digits_zero all three entry digits are 0
module keypad_loader #(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic [9:0] keypad,
  input  logic       load_en,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min,
  output logic       digits_zero
);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, ACCEPT, HELD} state_t;
  localparam logic [3:0] DC = 4'(DEBOUNCE_CYCLES);
  state_t state, state_n;
  logic [9:0] s1, s2, pat_r, pat_n;
  logic [3:0] cnt, cnt_n, code, min_n, tens_n, ones_n;
  logic one_hot, released, accept, shift;
  assign one_hot = s2 != 10'd0 && (s2 & (s2 - 10'd1)) == 10'd0;
  assign released = s2 == 10'd0;
  assign accept = state == ACCEPT;
  assign shift = accept && load_en;
  assign min_n = shift ? sec_tens : min;
  assign tens_n = shift ? sec_ones : sec_tens;
  assign ones_n = shift ? code : sec_ones;
  always_comb begin
    code = 4'd0;
    for (int i = 0; i < 10; i++)
      if (pat_r[i]) code = 4'(i);
  end
  // One counter serves both the press debounce and the release debounce.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    pat_n = pat_r;
    case (state)
      IDLE:
        if (one_hot) begin
          pat_n = s2;
          cnt_n = 4'd1;
          state_n = DC == 4'd1 ? ACCEPT : DEBOUNCE;
        end
      DEBOUNCE:
        if (s2 == pat_r) begin
          cnt_n = cnt + 4'd1;
          state_n = cnt_n == DC ? ACCEPT : DEBOUNCE;
        end else begin
          cnt_n = 4'd0;
          state_n = IDLE;
        end
      ACCEPT: begin
        cnt_n = 4'd0;
        state_n = HELD;
      end
      HELD: begin
        // Multi-key patterns are not a release, so they restart the count.
        cnt_n = released ? cnt + 4'd1 : 4'd0;
        if (cnt_n == DC) begin
          cnt_n = 4'd0;
          state_n = IDLE;
        end
      end
    endcase
  end
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state <= IDLE;
      cnt <= 4'd0;
      s1 <= 10'd0;
      s2 <= 10'd0;
      pat_r <= 10'd0;
      key_valid <= 1'b0;
      key_code <= 4'd0;
      min <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      digits_zero <= 1'b1;
    end else begin
      s1 <= keypad;
      s2 <= s1;
      state <= state_n;
      cnt <= cnt_n;
      pat_r <= pat_n;
      key_valid <= accept;
      key_code <= accept ? code : key_code;
      min <= min_n;
      sec_tens <= tens_n;
      sec_ones <= ones_n;
      digits_zero <= {min_n, tens_n, ones_n} == 12'd0;
    end
  end
endmodule

// File: tb/tb_keypad_loader.sv
// tb_keypad_loader: randomized and directed self-checking bench for keypad_loader
module tb_keypad_loader;
  localparam int D = 2;
  logic clock = 1'b0, clearn = 1'b1, load_en = 1'b0;
  logic [9:0] keypad = 10'd0;
  logic key_valid, digits_zero;
  logic [3:0] key_code, sec_ones, sec_tens, min;
  int n_cmp = 0, n_bad = 0;
  logic [3:0] m_min = 0, m_tens = 0, m_ones = 0, m_code = 0;

  keypad_loader #(.DEBOUNCE_CYCLES(D)) dut (
    .clock(clock), .clearn(clearn), .keypad(keypad), .load_en(load_en),
    .key_valid(key_valid), .key_code(key_code), .sec_ones(sec_ones),
    .sec_tens(sec_tens), .min(min), .digits_zero(digits_zero)
  );

  always #5 clock = ~clock;

  // Drive pattern a for h1 edges, then b for h2 edges, then release for r edges.
  // Records how many key_valid pulses were seen and the edge of the first one.
  task automatic press(input logic [9:0] a, input int h1, input logic [9:0] b, input int h2,
                       input int r, input logic le, output int np, output int first);
    load_en = le;
    np = 0;
    first = -1;
    for (int k = 1; k <= h1 + h2 + r; k++) begin
      keypad = k <= h1 ? a : (k <= h1 + h2 ? b : 10'd0);
      @(posedge clock);
      #1;
      if (key_valid === 1'b1) begin
        np++;
        if (first < 0) first = k;
      end
    end
    keypad = 10'd0;
  endtask

  // Reference: a one-hot pattern held for at least D synchronised cycles is one accepted digit.
  task automatic model_press(input logic [9:0] p, input int h, input logic le, output int exp_np);
    int d;
    d = -1;
    for (int i = 0; i < 10; i++) if (p == 10'(1 << i)) d = i;
    exp_np = (d >= 0 && h >= D) ? 1 : 0;
    if (exp_np == 1) begin
      m_code = 4'(d);
      if (le) begin
        m_min = m_tens;
        m_tens = m_ones;
        m_ones = 4'(d);
      end
    end
  endtask

  task automatic test_reset;
    int np, first;
    #1 clearn = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    n_cmp++;
    if ({key_valid, key_code, min, sec_tens, sec_ones, digits_zero} !== 18'd1) begin
      n_bad++;
      $display("FAIL reset_state got kv=%b code=%0d %0d:%0d%0d dz=%b want all 0, dz=1",
               key_valid, key_code, min, sec_tens, sec_ones, digits_zero);
    end
    @(negedge clock);
    clearn = 1'b1;
    press(10'd0, 0, 10'd0, 0, 6, 1'b1, np, first);
    n_cmp++;
    if (np !== 0) begin n_bad++; $display("FAIL reset_idle pulses got %0d want 0", np); end
  endtask

  task automatic test_entry;
    int np, first, en;
    int keys[3] = '{0, 9, 9};
    foreach (keys[i]) begin
      model_press(10'(1 << keys[i]), 5, 1'b1, en);
      press(10'(1 << keys[i]), 5, 10'd0, 0, 8, 1'b1, np, first);
      n_cmp++;
      if (np !== en) begin n_bad++; $display("FAIL entry_pulses key %0d got %0d want %0d", keys[i], np, en); end
      n_cmp++;
      if (first !== D + 3) begin n_bad++; $display("FAIL entry_latency key %0d got edge %0d want %0d", keys[i], first, D + 3); end
    end
    n_cmp++;
    if ({min, sec_tens, sec_ones, key_code, digits_zero} !== {4'd0, 4'd9, 4'd9, 4'd9, 1'b0}) begin
      n_bad++;
      $display("FAIL entry_digits got %0d:%0d%0d code=%0d dz=%b want 0:99 code=9 dz=0",
               min, sec_tens, sec_ones, key_code, digits_zero);
    end
  endtask

  task automatic test_bounce;
    int np, first;
    press(10'b0000100000, 1, 10'd0, 0, 8, 1'b1, np, first);
    n_cmp++;
    if (np !== 0) begin n_bad++; $display("FAIL bounce_single pulses got %0d want 0", np); end
    press(10'b0000100000, 1, 10'b0001000000, 1, 8, 1'b1, np, first);
    n_cmp++;
    if (np !== 0) begin n_bad++; $display("FAIL bounce_double pulses got %0d want 0", np); end
    n_cmp++;
    if ({min, sec_tens, sec_ones} !== {m_min, m_tens, m_ones}) begin
      n_bad++;
      $display("FAIL bounce_digits got %0d:%0d%0d want %0d:%0d%0d", min, sec_tens, sec_ones, m_min, m_tens, m_ones);
    end
  endtask

  task automatic test_overflow;
    int np, first, en;
    for (int k = 1; k <= 4; k++) begin
      model_press(10'(1 << k), 4, 1'b1, en);
      press(10'(1 << k), 4, 10'd0, 0, 8, 1'b1, np, first);
    end
    n_cmp++;
    if ({min, sec_tens, sec_ones, digits_zero} !== {4'd2, 4'd3, 4'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL overflow got %0d:%0d%0d dz=%b want 2:34 dz=0", min, sec_tens, sec_ones, digits_zero);
    end
  endtask

  task automatic test_frozen;
    int np, first, en;
    model_press(10'b0010000000, 40, 1'b0, en);
    press(10'b0010000000, 40, 10'd0, 0, 8, 1'b0, np, first);
    n_cmp++;
    if (np !== 1) begin n_bad++; $display("FAIL frozen_pulses got %0d want 1", np); end
    n_cmp++;
    if (key_code !== 4'd7) begin n_bad++; $display("FAIL frozen_code got %0d want 7", key_code); end
    n_cmp++;
    if ({min, sec_tens, sec_ones} !== {4'd2, 4'd3, 4'd4}) begin
      n_bad++;
      $display("FAIL frozen_digits got %0d:%0d%0d want 2:34", min, sec_tens, sec_ones);
    end
    load_en = 1'b1;
  endtask

  task automatic test_multikey;
    int np, first, en;
    press(10'b0000000110, 10, 10'd0, 0, 8, 1'b1, np, first);
    n_cmp++;
    if (np !== 0) begin n_bad++; $display("FAIL multikey_pulses got %0d want 0", np); end
    model_press(10'b0000100000, 5, 1'b1, en);
    press(10'b0000100000, 5, 10'd0, 0, 8, 1'b1, np, first);
    n_cmp++;
    if (np !== 1 || key_code !== 4'd5) begin
      n_bad++;
      $display("FAIL multikey_then5 got pulses=%0d code=%0d want 1 and 5", np, key_code);
    end
  endtask

  task automatic test_switch;
    int np, first, en;
    model_press(10'b0000001000, 5, 1'b1, en);
    press(10'b0000001000, 5, 10'b0100000000, 6, 8, 1'b1, np, first);
    n_cmp++;
    if (np !== 1 || key_code !== 4'd3) begin
      n_bad++;
      $display("FAIL switch got pulses=%0d code=%0d want 1 and 3", np, key_code);
    end
  endtask

  task automatic test_reset_mid;
    int np, first;
    keypad = 10'b0000001000;
    repeat (3) @(posedge clock);
    #2 clearn = 1'b0;
    #1;
    m_min = 0; m_tens = 0; m_ones = 0; m_code = 0;
    n_cmp++;
    if ({key_valid, key_code, min, sec_tens, sec_ones, digits_zero} !== 18'd1) begin
      n_bad++;
      $display("FAIL reset_mid got kv=%b code=%0d %0d:%0d%0d dz=%b want all 0, dz=1",
               key_valid, key_code, min, sec_tens, sec_ones, digits_zero);
    end
    keypad = 10'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    clearn = 1'b1;
    press(10'd0, 0, 10'd0, 0, 10, 1'b1, np, first);
    n_cmp++;
    if (np !== 0) begin n_bad++; $display("FAIL reset_mid_spurious pulses got %0d want 0", np); end
  endtask

  task automatic test_random;
    int np, first, en, h, i, j;
    logic [9:0] p;
    logic le;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        i = $urandom_range(0, 9);
        j = (i + $urandom_range(1, 9)) % 10;
        p = 10'((1 << i) | (1 << j));
      end else p = 10'(1 << $urandom_range(0, 9));
      h = $urandom_range(1, 6);
      le = 1'($urandom_range(0, 1));
      model_press(p, h, le, en);
      press(p, h, 10'd0, 0, $urandom_range(8, 12), le, np, first);
      n_cmp++;
      if (np !== en || (en == 1 && first !== D + 3)) begin
        n_bad++;
        $display("FAIL rand_pulse #%0d pat=%b h=%0d got %0d@%0d want %0d@%0d", n, p, h, np, first, en, D + 3);
      end
      n_cmp++;
      if ({min, sec_tens, sec_ones, key_code, digits_zero} !==
          {m_min, m_tens, m_ones, m_code, {m_min, m_tens, m_ones} == 12'd0}) begin
        n_bad++;
        $display("FAIL rand_state #%0d got %0d:%0d%0d code=%0d dz=%b want %0d:%0d%0d code=%0d",
                 n, min, sec_tens, sec_ones, key_code, digits_zero, m_min, m_tens, m_ones, m_code);
      end
    end
  endtask

  initial begin
    test_reset;
    test_entry;
    test_bounce;
    test_overflow;
    test_frozen;
    test_multikey;
    test_switch;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
